// File: rtl/sim_ctrl_dev.sv
// Simulation-control bus slave: TOHOST pass/fail, console FIFO, 64-bit cycle counter, watchdog.
// State table:  RUN | program executing, counters live   DONE | result latched, terminal until reset
module sim_ctrl_dev #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] TIMEOUT_RST = 32'd0,
  parameter logic [63:0] CYCLE_INIT  = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        timeout
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] A_TOHOST  = 3'd0;
  localparam logic [2:0] A_CONSOLE = 3'd1;
  localparam logic [2:0] A_CYC_LO  = 3'd2;
  localparam logic [2:0] A_CYC_HI  = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;

  typedef enum logic {S_RUN, S_DONE} state_e;
  state_e state_q, state_d;

  logic [31:0] tohost_q, wd_q, wd_d, shadow_q, rdata_q, rdata_d;
  logic [63:0] cyc_q;
  logic        rvalid_q, pass_q, timeout_q;
  logic [30:0] fail_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic [2:0]  sel;
  logic        full, empty, accept, wr_acc, rd_acc, push, pop, run, th_valid, wd_wr, expire;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];
  assign sel    = addr[4:2];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  // Full is judged before any same-cycle pop, so a full FIFO always stalls once.
  assign ready  = !(req && we && (sel == A_CONSOLE) && be[0] && full);
  assign accept = req && ready;
  assign wr_acc = accept && we;
  assign rd_acc = accept && !we;
  assign run    = (state_q == S_RUN);
  assign push   = wr_acc && (sel == A_CONSOLE) && be[0];
  assign pop    = !empty && con_ready;
  assign th_valid = run && wr_acc && (sel == A_TOHOST) && (be == 4'hF) && (wdata != '0);
  assign wd_wr    = run && wr_acc && (sel == A_TIMEOUT) && (be != 4'h0);
  assign expire   = run && !wd_wr && (wd_q == 32'd1);

  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : mem_q[rptr_q];
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (run && (th_valid || expire)) state_d = S_DONE;
  end

  always_comb begin
    done      = (state_q == S_DONE);
    pass      = pass_q;
    fail_code = fail_q;
    timeout   = timeout_q;
  end

  always_comb begin
    wd_d = wd_q;
    if (wd_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) wd_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end else if (run && (wd_q != '0)) begin
      wd_d = wd_q - 32'd1;
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    case (sel)
      A_TOHOST:  rdata_d = tohost_q;
      A_CONSOLE: rdata_d = {16'd0, 8'(cnt_q), 6'd0, full, empty};
      A_CYC_LO:  rdata_d = cyc_q[31:0];
      A_CYC_HI:  rdata_d = shadow_q;
      A_TIMEOUT: rdata_d = wd_q;
      default:   rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_q  <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      fail_q    <= '0;
      wd_q      <= TIMEOUT_RST;
      cyc_q     <= CYCLE_INIT;
      shadow_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      // A TOHOST write landing on the expiry edge takes precedence over the watchdog.
      if (th_valid || expire) begin
        timeout_q <= !th_valid;
        pass_q    <= th_valid && (wdata == 32'd1);
        fail_q    <= th_valid ? ((wdata == 32'd1) ? 31'd0 : wdata[31:1]) : 31'h7FFF_FFFF;
      end
      if (th_valid) tohost_q <= wdata;
      if (run) cyc_q <= cyc_q + 64'd1;
      if (rd_acc && (sel == A_CYC_LO)) shadow_q <= cyc_q[63:32];
      wd_q     <= wd_d;
      rvalid_q <= rd_acc;
      rdata_q  <= rd_acc ? rdata_d : 32'd0;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata[7:0];
  end
endmodule
